mem_access_unit: RTL

- Load/store front-end that sits directly upstream of the unified word-addressed Memory block in the multi-cycle CPU.
- Accepts one byte/half/word request at a time from the datapath over a valid/ready handshake, and drives Memory's addr/din/mem_read/mem_write.
- Sign/zero-extends load data and performs read-modify-write for sub-word stores.
- Flags misaligned and out-of-range accesses without touching memory.

---
 rtl/mem_access_pkg.sv | 26 ++
 rtl/mem_lane_align.sv | 21 ++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared state enum, size codes and lane extract/merge helpers
package mem_access_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] sz, input logic uns);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    return sz == SZ_BYTE ? {{24{~uns & s[7]}}, s[7:0]} :
           sz == SZ_HALF ? {{16{~uns & s[15]}}, s[15:0]} : s;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] off, input logic [1:0] sz);
    logic [31:0] m;
    m = sz == SZ_BYTE ? 32'h0000_00ff : sz == SZ_HALF ? 32'h0000_ffff : 32'hffff_ffff;
    m = m << {off, 3'b000};
    return (old & ~m) | ((wd << {off, 3'b000}) & m);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational load lane extract/extend and store lane merge
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] old,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  // word-size merge ignores old, so word stores need no prior read
  always_comb begin
    rdata  = lane_extract(word, off, size, uns);
    merged = lane_merge(old, wdata, off, size);
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end with sub-word RMW; MEM_ACCESS_PERF_CNT_EN adds ld/st/err counters
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_DEPTH = 16384
`ifdef MEM_ACCESS_PERF_CNT_EN
  , parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_din,
  output logic                 mem_read,
  output logic                 mem_write,
`ifdef MEM_ACCESS_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0] ld_count,
  output logic [CNT_WIDTH-1:0] st_count,
  output logic [CNT_WIDTH-1:0] err_count,
`endif
  input  logic [31:0]          mem_dout
);

  state_t      state, state_n;
  logic [31:0] addr, wdata, merge, rdata_ext, merged;
  logic [1:0]  size;
  logic        uns, write, err, bad;

  assign bad = req_size == 2'd3
            || (req_size == SZ_HALF && req_addr[0])
            || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            || {2'b00, req_addr[31:2]} >= 32'(MEM_DEPTH);

  mem_lane_align u_align (
    .word   (mem_dout),
    .old    (merge),
    .wdata  (wdata),
    .off    (addr[1:0]),
    .size   (size),
    .uns    (uns),
    .rdata  (rdata_ext),
    .merged (merged)
  );

  // state register; reset returns to IDLE at once, dropping any pending write or response
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_n;

  // next state and memory/handshake outputs decoded from the current state
  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_n = bad ? RESP : !req_write ? LOAD : req_size == SZ_WORD ? WRITE : RMW_RD;
      end
      LOAD: begin
        mem_read = 1'b1;
        state_n  = RESP;
      end
      RMW_RD: begin
        mem_read = 1'b1;
        state_n  = WRITE;
      end
      WRITE: begin
        mem_write = 1'b1;
        state_n   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
    mem_addr = (state == LOAD || state == RMW_RD || state == WRITE) ? {addr[31:2], 2'b00} : '0;
    mem_din  = state == WRITE ? merged : '0;
    resp_err = resp_valid & err;
  end

  // request latch on accept, load result capture, and merge-word capture for RMW
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      addr       <= '0;
      wdata      <= '0;
      size       <= SZ_BYTE;
      uns        <= 1'b0;
      write      <= 1'b0;
      err        <= 1'b0;
      merge      <= '0;
      resp_rdata <= '0;
    end else if (state == IDLE && req_valid) begin
      addr       <= req_addr;
      wdata      <= req_wdata;
      size       <= req_size;
      uns        <= req_unsigned;
      write      <= req_write;
      err        <= bad;
      resp_rdata <= '0;
    end else if (state == LOAD) begin
      resp_rdata <= rdata_ext;
    end else if (state == RMW_RD) begin
      merge <= mem_dout;
    end

`ifdef MEM_ACCESS_PERF_CNT_EN
  // saturating per-type counters bumped on the response cycle; errors count only as errors
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ld_count  <= '0;
      st_count  <= '0;
      err_count <= '0;
    end else if (state == RESP) begin
      if (err && !(&err_count))                  err_count <= err_count + CNT_WIDTH'(1);
      else if (!err && write && !(&st_count))    st_count  <= st_count + CNT_WIDTH'(1);
      else if (!err && !write && !(&ld_count))   ld_count  <= ld_count + CNT_WIDTH'(1);
    end
`endif

endmodule
